// File: rtl/tile_dma_pkg.sv
// tile_dma_pkg: shared types and helpers for the tile_dma copy engine.
// Holds the FSM state enum, transfer direction constants and the lane-mask helper.
package tile_dma_pkg;

    localparam int unsigned DEF_LANES      = 4;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned MAX_LANES      = 64;

    localparam logic DIR_LOAD  = 1'b0;
    localparam logic DIR_STORE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_XFER,
        ST_DRAIN,
        ST_FIN
    } state_t;

    typedef logic [DEF_LANES*DEF_DATA_WIDTH-1:0] beat_t;

    // Lanes 0..n-1 set; n >= width gives all ones.
    function automatic logic [MAX_LANES-1:0] therm_mask(input int unsigned n);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/tile_dma_addr_gen.sv
// tile_dma_addr_gen: row/beat walker producing source/destination beat addresses,
// the tail write mask and, when PAD_EN is defined, the zero-pad lane mask.
module tile_dma_addr_gen
    import tile_dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LANES      = DEF_LANES,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic [ADDR_WIDTH-1:0] src_stride,
    input  logic [ADDR_WIDTH-1:0] dst_stride,
    input  logic [CNT_WIDTH-1:0]  rows,
    input  logic [CNT_WIDTH-1:0]  row_bytes,
    input  logic [7:0]            pad_top,
    input  logic [7:0]            pad_bottom,
    input  logic [7:0]            pad_left,
    input  logic [7:0]            pad_right,
    output logic [ADDR_WIDTH-1:0] src_addr,
    output logic [ADDR_WIDTH-1:0] dst_addr,
    output logic [LANES-1:0]      keep_mask,
    output logic [LANES-1:0]      len_mask,
    output logic                  last
);
    localparam int unsigned XW = CNT_WIDTH + 2;

    logic [XW-1:0]         row_len, out_rows, row_idx, offset;
    logic [ADDR_WIDTH-1:0] src_ptr, dst_ptr;
    logic                  last_beat;

    assign row_len   = XW'(pad_left) + XW'(row_bytes) + XW'(pad_right);
    assign out_rows  = XW'(pad_top) + XW'(rows) + XW'(pad_bottom);
    assign last_beat = (offset + XW'(LANES)) >= row_len;
    assign last      = last_beat && (row_idx == out_rows - XW'(1));
    assign src_addr  = src_ptr + ADDR_WIDTH'(offset);
    assign dst_addr  = dst_ptr + ADDR_WIDTH'(offset);
    assign len_mask  = LANES'(therm_mask(32'(row_len - offset)));

`ifdef PAD_EN
    always_comb begin
        keep_mask = '0;
        if (row_idx >= XW'(pad_top) && row_idx < XW'(pad_top) + XW'(rows)) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                keep_mask[i] = (offset + XW'(i) >= XW'(pad_left)) &&
                               (offset + XW'(i) <  XW'(pad_left) + XW'(row_bytes));
            end
        end
    end
`else
    assign keep_mask = '1;
`endif

    // Source pointer starts pad_top rows above src_base so every row just adds the stride.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_idx <= '0;
            offset  <= '0;
            src_ptr <= '0;
            dst_ptr <= '0;
        end else if (init) begin
            row_idx <= '0;
            offset  <= '0;
            src_ptr <= src_base - ADDR_WIDTH'(pad_top) * src_stride - ADDR_WIDTH'(pad_left);
            dst_ptr <= dst_base;
        end else if (step) begin
            if (last_beat) begin
                offset  <= '0;
                row_idx <= row_idx + XW'(1);
                src_ptr <= src_ptr + src_stride;
                dst_ptr <= dst_ptr + dst_stride;
            end else begin
                offset <= offset + XW'(LANES);
            end
        end
    end

endmodule

// File: rtl/tile_dma.sv
// tile_dma: descriptor-driven strided 2-D tile copy between DRAM and GLB.
// Load-side zero padding is compiled in only when PAD_EN is defined.
module tile_dma
    import tile_dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned LANES      = DEF_LANES,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        dir,
    input  logic [ADDR_WIDTH-1:0]       src_base,
    input  logic [ADDR_WIDTH-1:0]       dst_base,
    input  logic [ADDR_WIDTH-1:0]       src_stride,
    input  logic [ADDR_WIDTH-1:0]       dst_stride,
    input  logic [CNT_WIDTH-1:0]        rows,
    input  logic [CNT_WIDTH-1:0]        row_bytes,
    input  logic [7:0]                  pad_top,
    input  logic [7:0]                  pad_bottom,
    input  logic [7:0]                  pad_left,
    input  logic [7:0]                  pad_right,
    output logic                        busy,
    output logic                        finish,
    output logic                        err,
    output logic                        dram_we,
    output logic [ADDR_WIDTH-1:0]       dram_addr,
    output logic [LANES*DATA_WIDTH-1:0] dram_w_data,
    input  logic [LANES*DATA_WIDTH-1:0] dram_r_data,
    output logic [LANES-1:0]            glb_re,
    output logic [ADDR_WIDTH-1:0]       glb_r_addr,
    input  logic [LANES*DATA_WIDTH-1:0] glb_r_data,
    output logic [LANES-1:0]            glb_we,
    output logic [ADDR_WIDTH-1:0]       glb_w_addr,
    output logic [LANES*DATA_WIDTH-1:0] glb_w_data
);
    state_t                state;
    logic                  d_dir;
    logic [ADDR_WIDTH-1:0] d_src_base, d_dst_base, d_src_stride, d_dst_stride;
    logic [CNT_WIDTH-1:0]  d_rows, d_row_bytes;
    logic [7:0]            e_pad_top, e_pad_bottom, e_pad_left, e_pad_right;
    logic [ADDR_WIDTH-1:0] src_addr, dst_addr, dram_wr_addr;
    logic [LANES-1:0]      keep_mask, len_mask, keep_q;
    logic                  last, wr_load, reject, empty, rb_misaligned;

    assign rb_misaligned = (d_row_bytes % CNT_WIDTH'(LANES)) != '0;
    assign empty         = (d_rows == '0) || (d_row_bytes == '0);

`ifdef PAD_EN
    logic [7:0] d_pad_top, d_pad_bottom, d_pad_left, d_pad_right;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_pad_top    <= '0;
            d_pad_bottom <= '0;
            d_pad_left   <= '0;
            d_pad_right  <= '0;
        end else if (state == ST_IDLE && start) begin
            d_pad_top    <= pad_top;
            d_pad_bottom <= pad_bottom;
            d_pad_left   <= pad_left;
            d_pad_right  <= pad_right;
        end
    end

    assign e_pad_top    = (d_dir == DIR_LOAD) ? d_pad_top    : '0;
    assign e_pad_bottom = (d_dir == DIR_LOAD) ? d_pad_bottom : '0;
    assign e_pad_left   = (d_dir == DIR_LOAD) ? d_pad_left   : '0;
    assign e_pad_right  = (d_dir == DIR_LOAD) ? d_pad_right  : '0;
    assign reject = (d_dir == DIR_STORE) &&
                    (rb_misaligned || (|{d_pad_top, d_pad_bottom, d_pad_left, d_pad_right}));
`else
    logic pad_unused;
    assign pad_unused   = ^{pad_top, pad_bottom, pad_left, pad_right};
    assign e_pad_top    = '0;
    assign e_pad_bottom = '0;
    assign e_pad_left   = '0;
    assign e_pad_right  = '0;
    assign reject = (d_dir == DIR_STORE) && rb_misaligned;
`endif

    tile_dma_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LANES      (LANES),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .init       (state == ST_CHECK),
        .step       (state == ST_XFER),
        .src_base   (d_src_base),
        .dst_base   (d_dst_base),
        .src_stride (d_src_stride),
        .dst_stride (d_dst_stride),
        .rows       (d_rows),
        .row_bytes  (d_row_bytes),
        .pad_top    (e_pad_top),
        .pad_bottom (e_pad_bottom),
        .pad_left   (e_pad_left),
        .pad_right  (e_pad_right),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .keep_mask  (keep_mask),
        .len_mask   (len_mask),
        .last       (last)
    );

    // Reads are issued combinationally from the walker; writes land one cycle later from registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            finish       <= 1'b0;
            err          <= 1'b0;
            wr_load      <= 1'b0;
            dram_we      <= 1'b0;
            glb_we       <= '0;
            glb_w_addr   <= '0;
            dram_wr_addr <= '0;
            keep_q       <= '0;
            d_dir        <= DIR_LOAD;
            d_src_base   <= '0;
            d_dst_base   <= '0;
            d_src_stride <= '0;
            d_dst_stride <= '0;
            d_rows       <= '0;
            d_row_bytes  <= '0;
        end else begin
            finish  <= 1'b0;
            wr_load <= 1'b0;
            dram_we <= 1'b0;
            glb_we  <= '0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        d_dir        <= dir;
                        d_src_base   <= src_base;
                        d_dst_base   <= dst_base;
                        d_src_stride <= src_stride;
                        d_dst_stride <= dst_stride;
                        d_rows       <= rows;
                        d_row_bytes  <= row_bytes;
                        err          <= 1'b0;
                        busy         <= 1'b1;
                        state        <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (reject || empty) begin
                        err    <= reject;
                        finish <= 1'b1;
                        state  <= ST_FIN;
                    end else begin
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (d_dir == DIR_LOAD) begin
                        wr_load    <= 1'b1;
                        glb_we     <= len_mask;
                        glb_w_addr <= dst_addr;
                        keep_q     <= keep_mask;
                    end else begin
                        dram_we      <= 1'b1;
                        dram_wr_addr <= dst_addr;
                    end
                    if (last) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    finish <= 1'b1;
                    state  <= ST_FIN;
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dram_addr   = (state == ST_XFER && d_dir == DIR_LOAD) ? src_addr :
                         (dram_we ? dram_wr_addr : '0);
    assign dram_w_data = dram_we ? glb_r_data : '0;
    assign glb_re      = (state == ST_XFER && d_dir == DIR_STORE) ? '1 : '0;
    assign glb_r_addr  = (state == ST_XFER && d_dir == DIR_STORE) ? src_addr : '0;

    always_comb begin
        glb_w_data = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (wr_load && keep_q[i])
                glb_w_data[i*DATA_WIDTH +: DATA_WIDTH] = dram_r_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_tile_dma.sv
// tb_tile_dma: scoreboard bench for tile_dma with byte-level DRAM/GLB memory models.
// Expected beats and finish events are queued at start; a negedge monitor pops and compares.
module tb_tile_dma;
    import tile_dma_pkg::*;

    localparam int LN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [31:0] src_base = '0, dst_base = '0, src_stride = '0, dst_stride = '0;
    logic [15:0] rows = '0, row_bytes = '0;
    logic [7:0]  pad_top = '0, pad_bottom = '0, pad_left = '0, pad_right = '0;
    logic        busy, finish, err, dram_we;
    logic [31:0] dram_addr, glb_r_addr, glb_w_addr;
    beat_t       dram_w_data, dram_r_data, glb_r_data, glb_w_data;
    logic [3:0]  glb_re, glb_we;

    tile_dma #(.ADDR_WIDTH(32), .DATA_WIDTH(8), .LANES(LN), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir),
        .src_base(src_base), .dst_base(dst_base), .src_stride(src_stride), .dst_stride(dst_stride),
        .rows(rows), .row_bytes(row_bytes),
        .pad_top(pad_top), .pad_bottom(pad_bottom), .pad_left(pad_left), .pad_right(pad_right),
        .busy(busy), .finish(finish), .err(err),
        .dram_we(dram_we), .dram_addr(dram_addr), .dram_w_data(dram_w_data), .dram_r_data(dram_r_data),
        .glb_re(glb_re), .glb_r_addr(glb_r_addr), .glb_r_data(glb_r_data),
        .glb_we(glb_we), .glb_w_addr(glb_w_addr), .glb_w_data(glb_w_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] dram_mem [0:1023];
    logic [7:0] glb_mem  [0:1023];
    logic [7:0] exp_dram [0:1023];
    logic [7:0] exp_glb  [0:1023];

    always @(posedge clk) begin : mem_model
        logic [31:0] a;
        if (cyc == 0) begin
            for (int i = 0; i < 1024; i++) begin
                dram_mem[i] <= 8'($urandom);
                glb_mem[i]  <= 8'($urandom);
            end
        end else begin
            for (int i = 0; i < LN; i++) begin
                a = dram_addr + 32'(i);
                dram_r_data[8*i +: 8] <= dram_mem[a[9:0]];
                a = glb_r_addr + 32'(i);
                glb_r_data[8*i +: 8] <= glb_mem[a[9:0]];
                if (glb_we[i]) begin
                    a = glb_w_addr + 32'(i);
                    glb_mem[a[9:0]] <= glb_w_data[8*i +: 8];
                end
                if (dram_we) begin
                    a = dram_addr + 32'(i);
                    dram_mem[a[9:0]] <= dram_w_data[8*i +: 8];
                end
            end
        end
    end

    typedef struct {
        bit          st;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    typedef struct {
        int cyc;
        bit err;
    } fin_t;

    wr_t  wq[$];
    fin_t fq[$];
    int   checks = 0;
    int   errors = 0;
    int   fin_count = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] bytemask(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < LN; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        wr_t  w;
        fin_t f;
        if (!rst) begin
            if (glb_we != '0 || dram_we) begin
                chk("write_expected", 64'(wq.size() != 0), 64'(1));
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    chk("wr_is_store", 64'(dram_we), 64'(w.st));
                    chk("wr_cycle", 64'(cyc), 64'(w.cyc));
                    if (w.st) begin
                        chk("dram_addr", 64'(dram_addr), 64'(w.addr));
                        chk("dram_data", 64'(dram_w_data), 64'(w.data));
                    end else begin
                        chk("glb_addr", 64'(glb_w_addr), 64'(w.addr));
                        chk("glb_mask", 64'(glb_we), 64'(w.mask));
                        chk("glb_data", 64'(glb_w_data & bytemask(w.mask)),
                            64'(w.data & bytemask(w.mask)));
                    end
                end
            end
            if (finish) begin
                chk("finish_expected", 64'(fq.size() != 0), 64'(1));
                if (fq.size() != 0) begin
                    f = fq.pop_front();
                    chk("finish_cycle", 64'(cyc), 64'(f.cyc));
                    chk("finish_err", 64'(err), 64'(f.err));
                end
                fin_count++;
            end
        end
    end

    task automatic cmp_mem();
        int bad_g = 0;
        int bad_d = 0;
        for (int i = 0; i < 1024; i++) begin
            if (glb_mem[i] !== exp_glb[i]) bad_g++;
            if (dram_mem[i] !== exp_dram[i]) bad_d++;
        end
        chk("glb_contents", 64'(bad_g), 64'(0));
        chk("dram_contents", 64'(bad_d), 64'(0));
    endtask

    // Byte-level reference: every output byte is derived from its tile coordinates.
    task automatic run(input logic d, input logic [31:0] sb, db, ss, ds,
                       input logic [15:0] nr, rb, input logic [7:0] pt, pb, pl, pr,
                       input int poke, input int rst_at);
        int ept, epb, epl, epr, L, H, B, n, s, f0, qlim, mlim, k, o, sr, col, t;
        bit rej, emp;
        wr_t w;
        fin_t f;
        logic [31:0] a;
        logic [7:0] by;
`ifdef PAD_EN
        ept = d ? 0 : int'(pt);
        epb = d ? 0 : int'(pb);
        epl = d ? 0 : int'(pl);
        epr = d ? 0 : int'(pr);
        rej = d && (((rb % 16'd4) != 0) || ((pt | pb | pl | pr) != 0));
`else
        ept = 0; epb = 0; epl = 0; epr = 0;
        rej = d && ((rb % 16'd4) != 0);
`endif
        emp = (nr == 0) || (rb == 0);
        L = epl + int'(rb) + epr;
        H = ept + int'(nr) + epb;
        B = (L + LN - 1) / LN;
        n = (rej || emp) ? 0 : H * B;
        qlim = (rst_at < 0) ? n : rst_at;
        mlim = (rst_at < 0) ? n : rst_at + 1;

        @(posedge clk); #1;
        dir = d; src_base = sb; dst_base = db; src_stride = ss; dst_stride = ds;
        rows = nr; row_bytes = rb; pad_top = pt; pad_bottom = pb; pad_left = pl; pad_right = pr;
        start = 1'b1;
        s = cyc;
        f0 = fin_count;
        for (int r = 0; r < H; r++) begin
            for (int b = 0; b < B; b++) begin
                if (n == 0) break;
                k = r * B + b;
                o = b * LN;
                w.st = d; w.cyc = s + 3 + k; w.mask = '0; w.data = '0;
                w.addr = db + 32'(r) * ds + 32'(o);
                for (int i = 0; i < LN; i++) begin
                    if (o + i < L) begin
                        w.mask[i] = 1'b1;
                        if (!d) begin
                            sr = r - ept;
                            col = o + i - epl;
                            by = 8'h00;
                            if (sr >= 0 && sr < int'(nr) && col >= 0 && col < int'(rb)) begin
                                a = sb + 32'(sr) * ss + 32'(col);
                                by = dram_mem[a[9:0]];
                            end
                        end else begin
                            a = sb + 32'(r) * ss + 32'(o + i);
                            by = glb_mem[a[9:0]];
                        end
                        w.data[8*i +: 8] = by;
                        if (k < mlim) begin
                            a = w.addr + 32'(i);
                            if (d) exp_dram[a[9:0]] = by;
                            else   exp_glb[a[9:0]]  = by;
                        end
                    end
                end
                if (k < qlim) wq.push_back(w);
            end
        end
        if (rst_at < 0) begin
            f.cyc = s + ((n != 0) ? n + 3 : 2);
            f.err = rej;
            fq.push_back(f);
        end

        @(posedge clk); #1;
        start = 1'b0;
        dir = 1'($urandom); src_base = $urandom; dst_base = $urandom;
        src_stride = $urandom; dst_stride = $urandom;
        rows = 16'($urandom); row_bytes = 16'($urandom);
        pad_top = 8'($urandom); pad_left = 8'($urandom);

        if (poke > 0) begin
            repeat (poke - 1) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end

        if (rst_at >= 0) begin
            repeat (2 + rst_at) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            @(negedge clk);
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_glb_we", 64'(glb_we), 64'(0));
            chk("rst_dram_we", 64'(dram_we), 64'(0));
            repeat (6) @(posedge clk);
            chk("rst_finish_count", 64'(fin_count), 64'(f0));
        end else begin
            t = 0;
            while (fin_count == f0 && t < 300) begin
                @(posedge clk);
                t++;
            end
            chk("finish_seen", 64'(fin_count != f0), 64'(1));
            @(negedge clk);
            chk("busy_after_finish", 64'(busy), 64'(0));
            chk("err_held", 64'(err), 64'(rej));
            repeat (3) @(posedge clk);
        end
        chk("writes_outstanding", 64'(wq.size()), 64'(0));
        cmp_mem();
    endtask

    initial begin : stim
        logic        d;
        logic [15:0] nr, rb;
        logic [7:0]  pt, pb, pl, pr;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 1024; i++) begin
            exp_dram[i] = dram_mem[i];
            exp_glb[i]  = glb_mem[i];
        end
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_finish", 64'(finish), 64'(0));
        chk("reset_err", 64'(err), 64'(0));
        chk("reset_strobes", 64'({glb_we, glb_re, dram_we}), 64'(0));
        #1 rst = 1'b0;

        run(DIR_LOAD, 32'h040, 32'h100, 8, 8, 3, 8, 0, 0, 0, 0, 0, -1);
        run(DIR_LOAD, 32'h080, 32'h140, 6, 8, 3, 6, 0, 0, 0, 0, 0, -1);
        run(DIR_LOAD, 32'h0C0, 32'h180, 4, 8, 2, 4, 1, 1, 1, 1, 0, -1);
        run(DIR_STORE, 32'h200, 32'h240, 8, 12, 2, 8, 0, 0, 0, 0, 0, -1);
        run(DIR_STORE, 32'h200, 32'h280, 8, 8, 2, 6, 0, 0, 0, 0, 0, -1);
        run(DIR_STORE, 32'h210, 32'h2C0, 8, 8, 2, 8, 0, 0, 1, 0, 0, -1);
        run(DIR_LOAD, 32'h040, 32'h300, 8, 8, 0, 8, 0, 0, 0, 0, 0, -1);
        run(DIR_LOAD, 32'h040, 32'h320, 8, 8, 3, 8, 0, 0, 0, 0, 0, 2);
        run(DIR_LOAD, 32'h050, 32'h340, 8, 8, 4, 8, 0, 0, 0, 0, 4, -1);

        for (int t = 0; t < 24; t++) begin
            d  = ($urandom_range(0, 2) == 0) ? DIR_STORE : DIR_LOAD;
            nr = 16'($urandom_range(0, 4));
            pt = '0; pb = '0; pl = '0; pr = '0;
            if (d == DIR_STORE) begin
                rb = 16'(4 * $urandom_range(1, 3) + (($urandom_range(0, 5) == 0) ? 2 : 0));
                if ($urandom_range(0, 5) == 0) pl = 8'd1;
            end else begin
                rb = 16'($urandom_range(1, 11));
                pt = 8'($urandom_range(0, 2)); pb = 8'($urandom_range(0, 2));
                pl = 8'($urandom_range(0, 2)); pr = 8'($urandom_range(0, 2));
            end
            run(d, 32'($urandom_range(0, 400)), 32'($urandom_range(0, 400)),
                32'(rb) + 32'($urandom_range(0, 6)), 32'(rb) + 32'($urandom_range(0, 10)),
                nr, rb, pt, pb, pl, pr, 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
